array_sort_check_datapath: RTL and testbench
============================================

# array_sort_check_datapath

Datapath partner of the array-sort-check control FSM. Holds a small internal array, captures an array length, walks an index register under the control strobes `load_input`, `load_index` and `select_index`, and returns the status flags `inversion_found`, `end_of_array` and `zero_length_array` that the FSM consumes. It also records the position of the first inversion found in each check, so software can read it after `done`.

## Interface
Parameters:
- `WIDTH`, default 32: element width in bits.
- `ADDR_W`, default 4: address width. Storage depth is `DEPTH = 2**ADDR_W`.

Ports:
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately, without waiting for a clock edge.
- `wr_en`, input, 1: write strobe for array storage.
- `wr_addr`, input, `ADDR_W`: write address.
- `wr_data`, input, `WIDTH`: write data.
- `length`, input, `ADDR_W+1`: element count, sampled on `load_input`.
- `load_input`, input, 1: capture `length`; restart the index.
- `load_index`, input, 1: index register enable.
- `select_index`, input, 1: when 1, the index increments; when 0, the index restarts at 1.
- `inversion_found`, output, 1: `arr[idx-1] > arr[idx]`, valid only while `idx` is in range.
- `end_of_array`, output, 1: all adjacent pairs have been compared.
- `zero_length_array`, output, 1: captured length is below 2 (array is trivially sorted).
- `first_inv_valid`, output, 1: an inversion has been recorded since the last `load_input`.
- `first_inv_addr`, output, `ADDR_W`: address of the left element of the first inversion.

## Operation
- **Storage:** `DEPTH` words of `WIDTH` bits.
  - Write is synchronous: `arr[wr_addr] <= wr_data` when `wr_en`.
  - Read is combinational.
  - All words clear to 0 on reset.
  - A write in cycle N is visible to comparisons from cycle N+1.
- **Length register `len`** (`ADDR_W+1` bits):
  - Loads `min(length, DEPTH)` when `load_input`.
  - Holds otherwise.
- **Index register `idx`** (`ADDR_W+1` bits), priority order:
  1. `load_input`: `idx <= 1`.
  2. `load_index & ~select_index`: `idx <= 1`.
  3. `load_index & select_index`: `idx <= idx + 1`, saturating at `len`.
  4. Otherwise `idx` holds.
- **Flags:** all combinational from registered state and storage.
  - `zero_length_array = (len < 2)`.
  - `end_of_array = (idx >= len)`.
  - `inversion_found = ~zero_length_array & ~end_of_array & (arr[idx-1] > arr[idx])`.
  - Forcing `inversion_found` to 0 at end or zero length guarantees the FSM never sees `inversion_found & end_of_array`.
- **First-inversion capture:**
  - `load_input` clears `first_inv_valid`.
  - Otherwise, on an edge where `inversion_found & ~first_inv_valid`: `first_inv_addr <= idx-1` and `first_inv_valid <= 1`.
  - Later inversions are ignored until the next `load_input`.
  - Simultaneous `load_input` and `inversion_found`: the clear wins.
- **Comparison:** unsigned by default (see Configuration).

## Timing
- Every output is a combinational function of registers and storage, so it is valid in the same cycle as the state that produces it. No output depends combinationally on `load_*` or `select_index`.
- Latency:
  - `load_input` at edge E: flags reflect the new `len` and `idx = 1` immediately after E.
  - Each increment edge advances the compared pair by one.
  - An array of length L with no inversion reaches `end_of_array` after L-1 increment edges.
- Reset values, applied asynchronously:
  - `len = 0` and `idx = 0`, so `zero_length_array = 1`, `end_of_array = 1`, `inversion_found = 0`.
  - `first_inv_valid = 0`, `first_inv_addr = 0`.
- Reset asserted mid-walk: all state clears immediately without a clock edge. Operation resumes from the reset values after deassertion.
- `length > DEPTH` is clamped to `DEPTH`. `length = 0` and `length = 1` behave identically.

## Configuration
- `SORT_CHECK_SIGNED_EN`:
  - Defined: the element comparison is two's-complement signed.
  - Undefined: the comparison is unsigned.
  - No other behaviour changes.

## Test plan
- **Reset:** assert `reset` between clock edges → outputs `zero_length_array=1`, `end_of_array=1`, `inversion_found=0`, `first_inv_valid=0` without a clock edge.
- **Sorted array:** write [1,2,3,4], `length=4`, one `load_input` edge, then increments → `inversion_found=0` at idx 1–3; `end_of_array=1` after 3 increment edges; `first_inv_valid=0`.
- **Unsorted array:** write [1,5,3,7], `length=4` → at idx=2, `inversion_found=1`; next edge `first_inv_valid=1`, `first_inv_addr=1`. A further inversion [.., 9, 2] does not change `first_inv_addr`.
- **Trivial lengths:** `length=1`, then `length=0` → `zero_length_array=1` and `inversion_found=0` right after each `load_input`. `length=20` → `len` clamps to 16; `end_of_array` after 15 increments.
- **Signed vs unsigned:** data [0xFFFFFFFF, 0x00000000], `length=2` → `inversion_found=1` without `SORT_CHECK_SIGNED_EN`, 0 with it.
- **Reset mid-walk:** assert `reset` at idx=3 during a check → `idx`, `len` and `first_inv_*` clear immediately; a subsequent `load_input` restarts at idx=1.

Source files
------------

// File: rtl/array_sort_check_datapath.sv
// Datapath for the array sort-check FSM: storage, length/index registers, status flags, first-inversion capture.
// Optional macro SORT_CHECK_SIGNED_EN selects a two's-complement element comparison (unsigned otherwise).
module array_sort_check_datapath #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W:0]   length,
    input  logic              load_input,
    input  logic              load_index,
    input  logic              select_index,
    output logic              inversion_found,
    output logic              end_of_array,
    output logic              zero_length_array,
    output logic              first_inv_valid,
    output logic [ADDR_W-1:0] first_inv_addr
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] arr;
    logic [ADDR_W:0]             len;
    logic [ADDR_W:0]             idx;
    logic [ADDR_W-1:0]           cur_addr;
    logic [ADDR_W-1:0]           prv_addr;
    logic [WIDTH-1:0]            left_val;
    logic [WIDTH-1:0]            right_val;
    logic                        greater;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arr <= '0;
        end else if (wr_en) begin
            arr[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len <= '0;
            idx <= '0;
        end else begin
            if (load_input)
                len <= (length > DEPTH_L) ? DEPTH_L : length;
            if (load_input || (load_index && !select_index))
                idx <= (ADDR_W+1)'(1);
            else if (load_index && (idx < len))
                idx <= idx + 1'b1;
        end
    end

    // Low address bits only; out-of-range indices are masked by the flag gating below.
    assign cur_addr  = idx[ADDR_W-1:0];
    assign prv_addr  = cur_addr - 1'b1;
    assign left_val  = arr[prv_addr];
    assign right_val = arr[cur_addr];

`ifdef SORT_CHECK_SIGNED_EN
    assign greater = $signed(left_val) > $signed(right_val);
`else
    assign greater = left_val > right_val;
`endif

    assign zero_length_array = (len < (ADDR_W+1)'(2));
    assign end_of_array      = (idx >= len);
    assign inversion_found   = !zero_length_array && !end_of_array && greater;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            first_inv_valid <= 1'b0;
            first_inv_addr  <= '0;
        end else if (load_input) begin
            first_inv_valid <= 1'b0;
        end else if (inversion_found && !first_inv_valid) begin
            first_inv_valid <= 1'b1;
            first_inv_addr  <= prv_addr;
        end
    end
endmodule

// File: tb/tb_array_sort_check_datapath.sv
// Directed self-checking bench for array_sort_check_datapath with hand-computed expectations.
module tb_array_sort_check_datapath;
    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  length;
    logic        load_input;
    logic        load_index;
    logic        select_index;
    logic        inversion_found;
    logic        end_of_array;
    logic        zero_length_array;
    logic        first_inv_valid;
    logic [3:0]  first_inv_addr;

    int n_pass = 0;
    int n_tot  = 0;
    int inv_cnt;

    array_sort_check_datapath #(.WIDTH(32), .ADDR_W(4)) dut (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .length(length), .load_input(load_input),
        .load_index(load_index), .select_index(select_index),
        .inversion_found(inversion_found), .end_of_array(end_of_array),
        .zero_length_array(zero_length_array),
        .first_inv_valid(first_inv_valid), .first_inv_addr(first_inv_addr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic load(input logic [4:0] l);
        length = l; load_input = 1'b1;
        step();
        load_input = 1'b0;
    endtask

    task automatic inc();
        load_index = 1'b1; select_index = 1'b1;
        step();
        load_index = 1'b0; select_index = 1'b0;
    endtask

    task automatic flags(input string tag, input logic zla, input logic eoa, input logic inv);
        chk({tag, "_zla"}, 32'(zero_length_array), 32'(zla));
        chk({tag, "_eoa"}, 32'(end_of_array), 32'(eoa));
        chk({tag, "_inv"}, 32'(inversion_found), 32'(inv));
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; length = '0;
        load_input = 1'b0; load_index = 1'b0; select_index = 1'b0;
        #2;
        flags("rst", 1, 1, 0);
        chk("rst_fiv", 32'(first_inv_valid), 0);
        chk("rst_fia", 32'(first_inv_addr), 0);
        #6 reset = 1'b0;

        // Sorted [1,2,3,4]
        for (int i = 0; i < 4; i++) wr(4'(i), 32'(i + 1));
        load(5'd4);
        flags("srt_i1", 0, 0, 0);
        inc(); flags("srt_i2", 0, 0, 0);
        inc(); flags("srt_i3", 0, 0, 0);
        inc(); flags("srt_end", 0, 1, 0);
        inc(); flags("srt_sat", 0, 1, 0);
        chk("srt_fiv", 32'(first_inv_valid), 0);

        // Unsorted [1,5,3,7,9,2], two inversions
        wr(0, 1); wr(1, 5); wr(2, 3); wr(3, 7); wr(4, 9); wr(5, 2);
        load(5'd6);
        flags("uns_i1", 0, 0, 0);
        inc(); flags("uns_i2", 0, 0, 1);
        chk("uns_fiv_pre", 32'(first_inv_valid), 0);
        inc();
        chk("uns_fiv", 32'(first_inv_valid), 1);
        chk("uns_fia", 32'(first_inv_addr), 1);
        inc(); inc(); flags("uns_i5", 0, 0, 1);
        inc(); flags("uns_end", 0, 1, 0);
        chk("uns_fia_keep", 32'(first_inv_addr), 1);
        chk("uns_fiv_keep", 32'(first_inv_valid), 1);
        load(5'd6);
        chk("uns_clr", 32'(first_inv_valid), 0);
        inc(); flags("uns_again", 0, 0, 1);
        load(5'd6);  // clear beats the simultaneous inversion capture
        chk("uns_clr_wins", 32'(first_inv_valid), 0);
        // select_index=0 restarts at idx 1
        inc(); inc(); inc();
        load_index = 1'b1; select_index = 1'b0; step(); load_index = 1'b0;
        inc(); flags("restart_i2", 0, 0, 1);

        // Trivial lengths and clamping
        load(5'd1); flags("len1", 1, 1, 0);
        load(5'd0); flags("len0", 1, 1, 0);
        for (int i = 0; i < 16; i++) wr(4'(i), 32'(i * 3));
        load(5'd20);
        inv_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            inv_cnt += int'(inversion_found);
            inc();
        end
        flags("clamp_14", 0, 0, 0);
        chk("clamp_inv_cnt", 32'(inv_cnt), 0);
        inc(); flags("clamp_15", 0, 1, 0);

        // Signed vs unsigned
        wr(0, 32'hFFFF_FFFF); wr(1, 32'h0);
        load(5'd2);
`ifdef SORT_CHECK_SIGNED_EN
        flags("sgn", 0, 0, 0);
`else
        flags("sgn", 0, 0, 1);
`endif

        // Reset mid-walk
        wr(0, 0); wr(1, 100);
        load(5'd8);
        inc(); flags("mid_i2", 0, 0, 1);
        inc();
        chk("mid_fiv", 32'(first_inv_valid), 1);
        chk("mid_fia", 32'(first_inv_addr), 1);
        #2 reset = 1'b1;
        #1;
        flags("mid_rst", 1, 1, 0);
        chk("mid_rst_fiv", 32'(first_inv_valid), 0);
        chk("mid_rst_fia", 32'(first_inv_addr), 0);
        #1 reset = 1'b0;
        load(5'd8);
        flags("post_rst_zero", 0, 0, 0);
        wr(0, 2); wr(1, 1);
        flags("post_rst_i1", 0, 0, 1);
        inc(); chk("post_rst_fia", 32'(first_inv_addr), 0);
        chk("post_rst_fiv", 32'(first_inv_valid), 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
